pmp_csr_ctrl: RTL and testbench
===============================

PMP_CSR_CTRL -- requirements
Module: pmp_csr_ctrl

Interface
REQ-001 SHALL have parameter NPHYS, default 56, physical address width.
REQ-002 SHALL have parameter NUM_PMP, default 5 (legal 1..16), number of implemented entries.
REQ-003 SHALL have one clock and synchronous active-high reset: clk input 1, reset input 1.
REQ-004 Ports SHALL be:
- csr_req  in  1  access request; held until csr_ack
- csr_we  in  1  1=write, 0=read
- csr_addr  in  12  CSR number
- csr_wdata  in  64  write data
- csr_rdata  out  64  read data, valid with csr_ack
- csr_ack  out  1  one-cycle completion pulse
- pmp_busy  out  1  decode in progress; checker results invalid
- pmp_valid  out  NUM_PMP  per-entry enable
- pmp_locked  out  NUM_PMP  per-entry L bit
- pmp_start  out  NUM_PMP*(NPHYS-2)  flat; entry i at [i*(NPHYS-2)+:NPHYS-2]; word address
- pmp_end  out  NUM_PMP*(NPHYS-2)  flat, inclusive word address
- pmp_prot  out  NUM_PMP*3  flat; entry i = {X,W,R}

Function
REQ-005 SHALL decode CSRs: 0x3A0 pmpcfg0 (entries 0-7, byte i = entry i), 0x3A2 pmpcfg2 (entries 8-15), 0x3B0+i pmpaddr i (bits [NPHYS-3:0] valid, upper bits read 0).
REQ-006 Cfg byte SHALL be R=bit0, W=bit1, X=bit2, A=bits[4:3] (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), L=bit7; bits 6:5 SHALL read 0.
REQ-007 Entries >= NUM_PMP and unlisted CSR numbers SHALL read 0 and ignore writes, still acked.
REQ-008 A cfg byte with W=1, R=0 SHALL be stored with W cleared.
REQ-009 Writes to a cfg byte or pmpaddr of a locked entry SHALL be ignored per-byte/per-register; pmpaddr i SHALL also be ignored when entry i+1 is locked with A=TOR.
REQ-010 FSM states SHALL be IDLE, RECALC, DONE; requests SHALL be sampled only in IDLE.
REQ-011 IDLE, csr_req & csr_we at edge T: CSR register updated at T, state->RECALC, idx=0, pmp_busy=1 from cycle T+1.
REQ-012 RECALC SHALL recompute entry idx each edge (T+1..T+NUM_PMP), idx++, then -> DONE; pmp_busy=0 in DONE.
REQ-013 IDLE, csr_req & !csr_we at edge T: csr_rdata latched at T, state->DONE; no recalculation.
REQ-014 DONE SHALL assert csr_ack for exactly one cycle then return to IDLE; csr_req SHALL be ignored in DONE; write ack cycle = T+NUM_PMP+1, read ack cycle = T+1.
REQ-015 csr_rdata SHALL hold its value until the next accepted read.
REQ-016 Entry decode (word units, a=pmpaddr i):
- OFF: valid=0
- TOR: start = i==0 ? 0 : pmpaddr i-1; end = a-1; valid = (a > start)
- NA4: start=end=a, valid=1
- NAPOT: m = a ^ (a+1) (NPHYS-2 bits); start = a & ~m; end = a | m; valid=1; a all-ones -> start 0, end all-ones
REQ-017 pmp_prot and pmp_locked for entry idx SHALL update in the same edge as its start/end/valid.
REQ-018 Entries not yet revisited in RECALC SHALL hold prior decoded values.

Reset
REQ-019 In reset: all cfg and pmpaddr registers 0, state IDLE, idx 0, all outputs 0 (csr_ack=0, pmp_busy=0, pmp_valid=0).
REQ-020 Reset SHALL override any state including mid-RECALC; no ack emitted for the aborted access.

Verification
REQ-021 NAPOT: write 0x3B0=0x8000_03FF, 0x3A0=0x1B -> entry0 start 0x8000_0000, end 0x8000_07FF, prot 3'b011, valid 1.
REQ-022 TOR: 0x3B0=0x100, 0x3B1=0x200, 0x3A0=0x0900 -> entry0 valid 0; entry1 start 0x100, end 0x1FF, prot 3'b001, valid 1; then 0x3B1=0x100 -> entry1 valid 0.
REQ-023 Lock: 0x3B0=0x40, 0x3A0=0x91; write 0x3B0=0x80 and 0x3A0=0x00 -> readback 0x40 and 0x91, entry0 locked 1, unchanged, each write still acked.
REQ-024 Timing (NUM_PMP=5): write accepted at edge T -> pmp_busy high cycles T+1..T+5, csr_ack only at T+6; read -> ack at T+1; csr_req held through DONE not re-accepted.
REQ-025 Reserved/range: 0x3A0=0xFFFF_FFFF_FFFF_FF62, 0x3BF write, 0x3A2 write -> readback 0x3A0 = 0x0000_0000_0000_0000 for bytes >= NUM_PMP, byte0 = 0x00 (W cleared, bits 6:5 zero, A=0), 0x3BF and 0x3A2 read 0.
REQ-026 Reset asserted at T+3 of a write -> next cycle all outputs 0, no csr_ack, next request accepted normally.

Source files
------------

// File: rtl/pmp_csr_ctrl.sv
// PMP CSR block: holds pmpcfg/pmpaddr registers and, after each write, walks the
// entries one per clock to refresh the decoded [start,end] word ranges.
module pmp_csr_ctrl #(
    parameter int NPHYS   = 56,
    parameter int NUM_PMP = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              csr_req,
    input  logic                              csr_we,
    input  logic [11:0]                       csr_addr,
    input  logic [63:0]                       csr_wdata,
    output logic [63:0]                       csr_rdata,
    output logic                              csr_ack,
    output logic                              pmp_busy,
    output logic [NUM_PMP-1:0]                pmp_valid,
    output logic [NUM_PMP-1:0]                pmp_locked,
    output logic [NUM_PMP*(NPHYS-2)-1:0]      pmp_start,
    output logic [NUM_PMP*(NPHYS-2)-1:0]      pmp_end,
    output logic [NUM_PMP*3-1:0]              pmp_prot
);

    localparam int AW   = NPHYS - 2;
    localparam int IDXW = (NUM_PMP > 1) ? $clog2(NUM_PMP) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PMP - 1);

    typedef enum logic [1:0] {IDLE, RECALC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IDXW-1:0] idx_reg;
    logic [63:0]     rdata_reg, rdata_next;

    logic [7:0]      cfg_reg   [NUM_PMP];
    logic [AW-1:0]   addr_reg  [NUM_PMP];
    logic [AW-1:0]   start_reg [NUM_PMP];
    logic [AW-1:0]   end_reg   [NUM_PMP];
    logic [2:0]      prot_reg  [NUM_PMP];
    logic [NUM_PMP-1:0] valid_reg, locked_reg;

    logic            is_cfg0, is_cfg2, is_addr;
    logic [3:0]      addr_sel;
    logic            accept, write_acc, read_acc;
    logic [NUM_PMP-1:0]   cfg_we, addr_we;
    logic [NUM_PMP*8-1:0] cfg_wdat;

    assign is_cfg0   = (csr_addr == 12'h3A0);
    assign is_cfg2   = (csr_addr == 12'h3A2);
    assign is_addr   = (csr_addr[11:4] == 8'h3B);
    assign addr_sel  = csr_addr[3:0];
    assign accept    = (state_reg == IDLE) && csr_req;
    assign write_acc = accept && csr_we;
    assign read_acc  = accept && !csr_we;

    generate
        for (genvar gi = 0; gi < NUM_PMP; gi++) begin : gen_entry
            logic [7:0] wbyte;
            logic       cfg_hit;
            logic       tor_guard;
            logic       unused_wbits;

            assign wbyte        = csr_wdata[(gi % 8) * 8 +: 8];
            assign unused_wbits = ^wbyte[6:5];
            assign cfg_hit      = (gi < 8) ? is_cfg0 : is_cfg2;
            // Reserved bits forced to zero; W without R is not a legal combination.
            assign cfg_wdat[gi*8 +: 8] = {wbyte[7], 2'b00, wbyte[4:3], wbyte[2],
                                          wbyte[1] & wbyte[0], wbyte[0]};

            // A locked TOR entry also freezes the base address held in the entry below it.
            if (gi + 1 < NUM_PMP) begin : gen_tor
                assign tor_guard = cfg_reg[gi+1][7] && (cfg_reg[gi+1][4:3] == 2'b01);
            end else begin : gen_last
                assign tor_guard = 1'b0;
            end

            assign cfg_we[gi]  = write_acc && cfg_hit && !cfg_reg[gi][7];
            assign addr_we[gi] = write_acc && is_addr && (addr_sel == 4'(gi)) &&
                                 !cfg_reg[gi][7] && !tor_guard;

            assign pmp_start[gi*AW +: AW] = start_reg[gi];
            assign pmp_end[gi*AW +: AW]   = end_reg[gi];
            assign pmp_prot[gi*3 +: 3]    = prot_reg[gi];
        end
    endgenerate

    always_comb begin
        rdata_next = '0;
        for (int i = 0; i < NUM_PMP; i++) begin
            if ((is_cfg0 && i < 8) || (is_cfg2 && i >= 8))
                rdata_next[(i % 8) * 8 +: 8] = cfg_reg[i];
            if (is_addr && addr_sel == 4'(i))
                rdata_next = 64'(addr_reg[i]);
        end
    end

    // Decode of the entry currently addressed by idx_reg.
    logic [AW-1:0] cur_a, prev_a, napot_m, dec_start, dec_end;
    logic [7:0]    cur_cfg;
    logic          dec_valid;
    logic          unused_sink;

    always_comb begin
        cur_a     = addr_reg[idx_reg];
        cur_cfg   = cfg_reg[idx_reg];
        prev_a    = (idx_reg == '0) ? '0 : addr_reg[idx_reg - IDXW'(1)];
        napot_m   = cur_a ^ (cur_a + AW'(1));
        dec_start = '0;
        dec_end   = '0;
        dec_valid = 1'b0;
        case (cur_cfg[4:3])
            2'b01: begin
                dec_start = prev_a;
                dec_end   = cur_a - AW'(1);
                dec_valid = (cur_a > prev_a);
            end
            2'b10: begin
                dec_start = cur_a;
                dec_end   = cur_a;
                dec_valid = 1'b1;
            end
            2'b11: begin
                dec_start = cur_a & ~napot_m;
                dec_end   = cur_a | napot_m;
                dec_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign unused_sink = ^{csr_wdata, cur_cfg[6:5]};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (csr_req) state_next = csr_we ? RECALC : DONE;
            RECALC:  if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            rdata_reg  <= '0;
            valid_reg  <= '0;
            locked_reg <= '0;
            for (int i = 0; i < NUM_PMP; i++) begin
                cfg_reg[i]   <= '0;
                addr_reg[i]  <= '0;
                start_reg[i] <= '0;
                end_reg[i]   <= '0;
                prot_reg[i]  <= '0;
            end
        end else begin
            state_reg <= state_next;
            for (int i = 0; i < NUM_PMP; i++) begin
                if (cfg_we[i])  cfg_reg[i]  <= cfg_wdat[i*8 +: 8];
                if (addr_we[i]) addr_reg[i] <= csr_wdata[AW-1:0];
            end
            if (read_acc)
                rdata_reg <= rdata_next;
            if (write_acc) begin
                idx_reg <= '0;
            end else if (state_reg == RECALC) begin
                start_reg[idx_reg]  <= dec_start;
                end_reg[idx_reg]    <= dec_end;
                valid_reg[idx_reg]  <= dec_valid;
                locked_reg[idx_reg] <= cur_cfg[7];
                prot_reg[idx_reg]   <= cur_cfg[2:0];
                idx_reg             <= idx_reg + IDXW'(1);
            end
        end
    end

    assign csr_rdata  = rdata_reg;
    assign csr_ack    = (state_reg == DONE);
    assign pmp_busy   = (state_reg == RECALC);
    assign pmp_valid  = valid_reg;
    assign pmp_locked = locked_reg;

endmodule

// File: tb/tb_pmp_csr_ctrl.sv
// Scoreboarded bench for pmp_csr_ctrl: driver pushes expected acks, a negedge monitor
// pops and compares them and tracks the progressive entry refresh against a model.
module tb_pmp_csr_ctrl;

    localparam int NP  = 5;
    localparam int NPH = 56;
    localparam int AW  = NPH - 2;
    localparam longint unsigned MASK = (64'd1 << AW) - 64'd1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              csr_req = 1'b0;
    logic              csr_we = 1'b0;
    logic [11:0]       csr_addr = '0;
    logic [63:0]       csr_wdata = '0;
    logic [63:0]       csr_rdata;
    logic              csr_ack;
    logic              pmp_busy;
    logic [NP-1:0]     pmp_valid;
    logic [NP-1:0]     pmp_locked;
    logic [NP*AW-1:0]  pmp_start;
    logic [NP*AW-1:0]  pmp_end;
    logic [NP*3-1:0]   pmp_prot;

    pmp_csr_ctrl #(.NPHYS(NPH), .NUM_PMP(NP)) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_req    (csr_req),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_ack    (csr_ack),
        .pmp_busy   (pmp_busy),
        .pmp_valid  (pmp_valid),
        .pmp_locked (pmp_locked),
        .pmp_start  (pmp_start),
        .pmp_end    (pmp_end),
        .pmp_prot   (pmp_prot)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit              v;
        bit              l;
        logic [2:0]      p;
        longint unsigned s;
        longint unsigned e;
    } dec_t;

    typedef struct {
        bit              we;
        logic [11:0]     addr;
        longint unsigned wdata;
        longint unsigned rd;
        int              t;
    } txn_t;

    txn_t            sb_q[$];
    bit [7:0]        m_cfg  [NP];
    longint unsigned m_addr [NP];
    dec_t            cur_dec[NP];
    dec_t            old_dec[NP];
    longint unsigned last_rd;
    bit              wr_active;
    int              wr_t;
    bit              ack_seen;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int e = 0; e < NP; e++) begin
            m_cfg[e]   = '0;
            m_addr[e]  = 0;
            cur_dec[e] = '{v: 1'b0, l: 1'b0, p: 3'b000, s: 0, e: 0};
            old_dec[e] = cur_dec[e];
        end
        last_rd   = 0;
        wr_active = 1'b0;
        sb_q.delete();
    endfunction

    function automatic bit addr_frozen(int i);
        if (m_cfg[i][7]) return 1'b1;
        if (i + 1 < NP && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'd1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_write(logic [11:0] a, longint unsigned d);
        bit [63:0] dd = d;
        bit [7:0]  b;
        int        i;
        if (a == 12'h3A0 || a == 12'h3A2) begin
            for (int e = 0; e < NP; e++) begin
                if ((e < 8) == (a == 12'h3A0) && !m_cfg[e][7]) begin
                    b = dd[(e % 8) * 8 +: 8] & 8'h9F;
                    if (!b[0]) b[1] = 1'b0;
                    m_cfg[e] = b;
                end
            end
        end else if (a[11:4] == 8'h3B) begin
            i = int'(a[3:0]);
            if (i < NP && !addr_frozen(i)) m_addr[i] = d & MASK;
        end
    endfunction

    function automatic longint unsigned m_read(logic [11:0] a);
        bit [63:0] r = '0;
        if (a == 12'h3A0 || a == 12'h3A2) begin
            for (int e = 0; e < NP; e++)
                if ((e < 8) == (a == 12'h3A0)) r[(e % 8) * 8 +: 8] = m_cfg[e];
        end else if (a[11:4] == 8'h3B && int'(a[3:0]) < NP) begin
            r = m_addr[int'(a[3:0])];
        end
        return r;
    endfunction

    function automatic dec_t decode_entry(int e);
        dec_t            d;
        longint unsigned a = m_addr[e];
        longint unsigned base;
        int              k;
        d.l = m_cfg[e][7];
        d.p = m_cfg[e][2:0];
        d.v = 1'b0;
        d.s = 0;
        d.e = 0;
        case (m_cfg[e][4:3])
            2'd1: begin
                base = 0;
                if (e > 0) base = m_addr[e-1];
                d.s = base;
                d.e = (a - 1) & MASK;
                d.v = (a > base);
            end
            2'd2: begin
                d.s = a;
                d.e = a;
                d.v = 1'b1;
            end
            2'd3: begin
                // Region of 2^(k+1) words where k = number of trailing ones.
                k = 0;
                while (k < AW && a[k]) k++;
                d.s = (a >> (k + 1)) << (k + 1);
                d.e = (d.s + (64'd1 << (k + 1)) - 1) & MASK;
                d.v = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic void decode_all();
        for (int e = 0; e < NP; e++) cur_dec[e] = decode_entry(e);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            int            j;
            logic [NP-1:0] ev, el;
            logic [3*NP-1:0] ep;
            dec_t          d;
            txn_t          t;
            j = wr_active ? (cyc - wr_t) : NP;
            for (int e = 0; e < NP; e++) begin
                d = (e < j) ? cur_dec[e] : old_dec[e];
                ev[e] = d.v;
                el[e] = d.l;
                ep[e*3 +: 3] = d.p;
            end
            check("decode_state", {pmp_valid, pmp_locked, pmp_prot}, {ev, el, ep});
            check("busy", 64'(pmp_busy), 64'(wr_active && j < NP));
            if (csr_ack) begin
                if (sb_q.size() == 0) begin
                    check("spurious_ack", 64'(csr_ack), 64'd0);
                end else begin
                    t = sb_q.pop_front();
                    check("ack_cycle", cyc, t.t + (t.we ? NP : 0));
                    check("rdata", csr_rdata, t.we ? last_rd : t.rd);
                    if (!t.we) last_rd = t.rd;
                    if (t.we) begin
                        for (int e = 0; e < NP; e++) begin
                            if (cur_dec[e].v) begin
                                check("start", 64'(pmp_start[e*AW +: AW]), cur_dec[e].s);
                                check("end", 64'(pmp_end[e*AW +: AW]), cur_dec[e].e);
                            end
                        end
                        wr_active = 1'b0;
                    end
                    $display("txn %s addr=0x%03h wdata=0x%016h rdata=0x%016h cycle=%0d",
                             t.we ? "WR" : "RD", t.addr, t.wdata, csr_rdata, cyc);
                end
                ack_seen = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input bit we, input logic [11:0] a, input longint unsigned d,
                         input bit use_exp, input longint unsigned exp_rd);
        txn_t t;
        csr_req   = 1'b1;
        csr_we    = we;
        csr_addr  = a;
        csr_wdata = d;
        ack_seen  = 1'b0;
        @(posedge clk);
        #1;
        t.we = we; t.addr = a; t.wdata = d; t.t = cyc;
        t.rd = use_exp ? exp_rd : m_read(a);
        if (we) begin
            old_dec = cur_dec;
            m_write(a, d);
            decode_all();
            wr_t      = cyc;
            wr_active = 1'b1;
        end
        sb_q.push_back(t);
    endtask

    task automatic access(input bit we, input logic [11:0] a, input longint unsigned d,
                          input bit use_exp, input longint unsigned exp_rd);
        int n;
        issue(we, a, d, use_exp, exp_rd);
        n = 0;
        // Request stays high through the ack cycle and one edge beyond it.
        while (!ack_seen && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        csr_req = 1'b0;
        csr_we  = 1'b0;
        if (!ack_seen) begin
            check("ack_timeout", 64'(ack_seen), 64'd1);
            sb_q.delete();
            wr_active = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        csr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {csr_ack, pmp_busy}, 64'd0);
        check({tag, "_valid_lock"}, {pmp_valid, pmp_locked}, 64'd0);
        check({tag, "_ranges"}, {|pmp_start, |pmp_end, |pmp_prot}, 64'd0);
        check({tag, "_rdata"}, csr_rdata, 64'd0);
    endtask

    task automatic rand_access();
        int              sel;
        logic [11:0]     a;
        longint unsigned d;
        bit              we;
        sel = $urandom_range(0, 11);
        case (sel)
            0, 1, 2:       a = 12'h3A0;
            3:             a = 12'h3A2;
            4, 5, 6, 7, 8: a = 12'h3B0 + 12'($urandom_range(0, 15));
            9:             a = 12'h3A1;
            10:            a = 12'h3A3;
            default:       a = 12'($urandom_range(0, 4095));
        endcase
        d = {$urandom, $urandom};
        if ((a == 12'h3A0 || a == 12'h3A2) && $urandom_range(0, 3) != 0)
            d = d & ~64'h8080_8080_8080_8080;
        if (a[11:4] == 8'h3B && $urandom_range(0, 1) == 1)
            d = longint'($urandom_range(0, 300));
        we = ($urandom_range(0, 2) != 0);
        access(we, a, d, 1'b0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // NAPOT region 0x8000_0000..0x8000_07FF, R+W
        access(1'b1, 12'h3B0, 64'h8000_03FF, 1'b0, 0);
        access(1'b1, 12'h3A0, 64'h1B, 1'b0, 0);
        check("napot_start", 64'(pmp_start[0 +: AW]), 64'h8000_0000);
        check("napot_end", 64'(pmp_end[0 +: AW]), 64'h8000_07FF);
        check("napot_prot", 64'(pmp_prot[2:0]), 64'd3);
        check("napot_valid", 64'(pmp_valid[0]), 64'd1);

        // TOR range for entry 1, then collapsed to empty
        access(1'b1, 12'h3B0, 64'h100, 1'b0, 0);
        access(1'b1, 12'h3B1, 64'h200, 1'b0, 0);
        access(1'b1, 12'h3A0, 64'h0900, 1'b0, 0);
        check("tor_e0_valid", 64'(pmp_valid[0]), 64'd0);
        check("tor_start", 64'(pmp_start[AW +: AW]), 64'h100);
        check("tor_end", 64'(pmp_end[AW +: AW]), 64'h1FF);
        check("tor_prot", 64'(pmp_prot[5:3]), 64'd1);
        check("tor_valid", 64'(pmp_valid[1]), 64'd1);
        access(1'b1, 12'h3B1, 64'h100, 1'b0, 0);
        check("tor_empty_valid", 64'(pmp_valid[1]), 64'd0);

        // Locked entry ignores later writes
        access(1'b1, 12'h3B0, 64'h40, 1'b0, 0);
        access(1'b1, 12'h3A0, 64'h91, 1'b0, 0);
        access(1'b1, 12'h3B0, 64'h80, 1'b0, 0);
        access(1'b1, 12'h3A0, 64'h00, 1'b0, 0);
        access(1'b0, 12'h3B0, 0, 1'b1, 64'h40);
        access(1'b0, 12'h3A0, 0, 1'b1, 64'h91);
        check("lock_locked", 64'(pmp_locked[0]), 64'd1);
        check("lock_start", 64'(pmp_start[0 +: AW]), 64'h40);
        check("lock_end", 64'(pmp_end[0 +: AW]), 64'h40);

        // Reserved bits, out-of-range entries and unimplemented CSRs
        do_reset();
        access(1'b1, 12'h3A0, 64'hFFFF_FFFF_FFFF_FF62, 1'b0, 0);
        access(1'b1, 12'h3BF, {$urandom, $urandom}, 1'b0, 0);
        access(1'b1, 12'h3A2, {$urandom, $urandom}, 1'b0, 0);
        access(1'b0, 12'h3A0, 0, 1'b1, 64'h0000_009F_9F9F_9F00);
        access(1'b0, 12'h3BF, 0, 1'b1, 64'h0);
        access(1'b0, 12'h3A2, 0, 1'b1, 64'h0);

        // Reset in the middle of a recalculation
        do_reset();
        access(1'b1, 12'h3B0, 64'h1FF, 1'b0, 0);
        access(1'b0, 12'h3B0, 0, 1'b1, 64'h1FF);
        issue(1'b1, 12'h3A0, 64'h18, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        csr_req   = 1'b0;
        wr_active = 1'b0;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero("abort");
        #1;
        reset = 1'b0;
        model_clear();
        access(1'b0, 12'h3A0, 0, 1'b1, 64'h0);
        access(1'b1, 12'h3B0, 64'h3, 1'b0, 0);
        access(1'b1, 12'h3A0, 64'h1F, 1'b0, 0);
        access(1'b0, 12'h3B0, 0, 1'b1, 64'h3);

        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int k = 0; k < 30; k++) rand_access();
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
